// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM soft-start/soft-stop sequencer.
// Holds the ramp FSM state encoding and the default speed bus width.
package pwm_pkg;

    localparam int DEF_SPEED_W = 3;
    localparam int SPEED_MAX   = (1 << DEF_SPEED_W) - 1;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_sync.sv
// Single-bit multi-flop synchronizer, resets to 0.
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronized).
module pwm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer feeding the PWM generator enable/speed pins.
// Ports: clk, rst_n, en_req/target/estop (async pins) -> pwm_enable,
// pwm_speed, busy, at_target, state_dbg.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int SPEED_W     = DEF_SPEED_W,
    parameter int STEP_CYCLES = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_req,
    input  logic [SPEED_W-1:0] target,
    input  logic               estop,
    output logic               pwm_enable,
    output logic [SPEED_W-1:0] pwm_speed,
    output logic               busy,
    output logic               at_target,
    output logic [1:0]         state_dbg
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [SPEED_W-1:0] SPD_TOP  = '1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(STEP_CYCLES - 1);

    // Bit order: {estop, en_req, target}
    logic [SPEED_W+1:0] raw;
    logic [SPEED_W+1:0] syn;
    logic [SPEED_W-1:0] tgt_s;
    logic               en_s;
    logic               stop_s;

    assign raw = {estop, en_req, target};

    for (genvar i = 0; i < SPEED_W + 2; i++) begin : g_sync
        pwm_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (raw[i]),
            .q    (syn[i])
        );
    end

    assign tgt_s  = syn[SPEED_W-1:0];
    assign en_s   = syn[SPEED_W];
    assign stop_s = syn[SPEED_W+1];

    logic [SPEED_W-1:0] goal;
    assign goal = en_s ? tgt_s : '0;

    state_t             state, state_n;
    logic [SPEED_W-1:0] spd, spd_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               pen;
    logic               busy_q;
    logic               tick;
    logic [SPEED_W-1:0] spd_inc;
    logic [SPEED_W-1:0] spd_dec;

    assign tick    = (cnt == CNT_LAST);
    assign spd_inc = spd + 1'b1;
    assign spd_dec = spd - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_OFF;
            spd    <= '0;
            cnt    <= '0;
            pen    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            spd    <= spd_n;
            cnt    <= cnt_n;
            pen    <= (state_n != ST_OFF);
            busy_q <= (state_n == ST_RAMP_UP) || (state_n == ST_RAMP_DOWN);
        end
    end

    // Counter defaults to 0 so every state change restarts the step interval;
    // it only advances while staying inside a ramp without a tick.
    always_comb begin
        state_n = state;
        spd_n   = spd;
        cnt_n   = '0;
        if (stop_s) begin
            state_n = ST_OFF;
            spd_n   = '0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    spd_n = '0;
                    if (goal != '0) state_n = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (goal < spd) begin
                        state_n = ST_RAMP_DOWN;
                    end else if (goal == spd) begin
                        // goal moved onto the current level mid-ramp
                        state_n = ST_HOLD;
                    end else if (tick) begin
                        if (spd != SPD_TOP) spd_n = spd_inc;
                        if (spd_inc == goal) state_n = ST_HOLD;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (goal > spd) begin
                        state_n = ST_RAMP_UP;
                    end else if (goal < spd) begin
                        state_n = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (goal > spd) begin
                        state_n = ST_RAMP_UP;
                    end else if (goal == spd) begin
                        state_n = (spd == '0) ? ST_OFF : ST_HOLD;
                    end else if (tick) begin
                        if (spd != '0) spd_n = spd_dec;
                        if (spd_dec == goal) begin
                            state_n = (spd_dec == '0) ? ST_OFF : ST_HOLD;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_OFF;
                    spd_n   = '0;
                end
            endcase
        end
    end

    assign pwm_enable = pen;
    assign pwm_speed  = spd;
    assign busy       = busy_q;
    assign at_target  = (spd == goal) && !busy_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with STEP_CYCLES=4, SYNC_STAGES=2.
// Vector table drives pins, advances N cycles and checks all outputs.
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en_req;
    logic [2:0] target;
    logic       estop;
    logic       pwm_enable;
    logic [2:0] pwm_speed;
    logic       busy;
    logic       at_target;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    pwm_ramp_ctrl #(
        .SPEED_W    (3),
        .STEP_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_req    (en_req),
        .target    (target),
        .estop     (estop),
        .pwm_enable(pwm_enable),
        .pwm_speed (pwm_speed),
        .busy      (busy),
        .at_target (at_target),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] tgt;
        logic       stop;
        int         adv;
        logic [1:0] st;
        logic [2:0] spd;
        logic       pen;
        logic       bsy;
        logic       at;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic en, input logic [2:0] tgt,
                       input logic stop, input int adv,
                       input logic [1:0] st, input logic [2:0] spd,
                       input logic pen, input logic bsy, input logic at);
        vec_t v;
        v.en = en; v.tgt = tgt; v.stop = stop; v.adv = adv;
        v.st = st; v.spd = spd; v.pen = pen; v.bsy = bsy; v.at = at;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st,
                           input logic [2:0] spd, input logic pen,
                           input logic bsy, input logic at);
        chk({tag, " state"}, {6'd0, state_dbg}, {6'd0, st});
        chk({tag, " speed"}, {5'd0, pwm_speed}, {5'd0, spd});
        chk({tag, " enable"}, {7'd0, pwm_enable}, {7'd0, pen});
        chk({tag, " busy"}, {7'd0, busy}, {7'd0, bsy});
        chk({tag, " at_target"}, {7'd0, at_target}, {7'd0, at});
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // ramp up 0 -> 5
        add(1, 5, 0, 2,  0, 0, 0, 0, 0);
        add(1, 5, 0, 1,  1, 0, 1, 1, 0);
        add(1, 5, 0, 3,  1, 0, 1, 1, 0);
        add(1, 5, 0, 1,  1, 1, 1, 1, 0);
        add(1, 5, 0, 4,  1, 2, 1, 1, 0);
        add(1, 5, 0, 4,  1, 3, 1, 1, 0);
        add(1, 5, 0, 4,  1, 4, 1, 1, 0);
        add(1, 5, 0, 4,  2, 5, 1, 0, 1);
        // down to 2 and hold
        add(1, 2, 0, 3,  3, 5, 1, 1, 0);
        add(1, 2, 0, 4,  3, 4, 1, 1, 0);
        add(1, 2, 0, 4,  3, 3, 1, 1, 0);
        add(1, 2, 0, 4,  2, 2, 1, 0, 1);
        // soft stop
        add(0, 2, 0, 3,  3, 2, 1, 1, 0);
        add(0, 2, 0, 4,  3, 1, 1, 1, 0);
        add(0, 2, 0, 4,  0, 0, 0, 0, 1);
        // reverse mid-ramp at speed 3 toward 7
        add(1, 7, 0, 3,  1, 0, 1, 1, 0);
        add(1, 7, 0, 12, 1, 3, 1, 1, 0);
        add(1, 1, 0, 3,  3, 3, 1, 1, 0);
        add(1, 1, 0, 4,  3, 2, 1, 1, 0);
        add(1, 1, 0, 4,  2, 1, 1, 0, 1);
        // up to 6, then estop for 10 cycles
        add(1, 6, 0, 3,  1, 1, 1, 1, 0);
        add(1, 6, 0, 20, 2, 6, 1, 0, 1);
        add(1, 6, 1, 2,  2, 6, 1, 0, 1);
        add(1, 6, 1, 1,  0, 0, 0, 0, 0);
        add(1, 6, 1, 7,  0, 0, 0, 0, 0);
        add(1, 6, 0, 2,  0, 0, 0, 0, 0);
        add(1, 6, 0, 1,  1, 0, 1, 1, 0);
        add(1, 6, 0, 4,  1, 1, 1, 1, 0);
        // saturate at max level
        add(1, 7, 0, 24, 2, 3'(pwm_pkg::SPEED_MAX), 1, 0, 1);
        add(1, 7, 0, 20, 2, 3'(pwm_pkg::SPEED_MAX), 1, 0, 1);
        // start a ramp down for the async reset test
        add(0, 7, 0, 3,  3, 7, 1, 1, 0);
        add(0, 7, 0, 4,  3, 6, 1, 1, 0);

        rst_n  = 1'b0;
        en_req = 1'($urandom);
        target = 3'($urandom);
        estop  = 1'($urandom);
        adv(3);
        chk_all("reset", 0, 0, 0, 0, 1);

        en_req = 1'b0;
        target = 3'd0;
        estop  = 1'b0;
        rst_n  = 1'b1;
        adv(6);
        chk_all("post_reset", 0, 0, 0, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            en_req = vq[i].en;
            target = vq[i].tgt;
            estop  = vq[i].stop;
            adv(vq[i].adv);
            chk_all($sformatf("v%0d", i), vq[i].st, vq[i].spd,
                    vq[i].pen, vq[i].bsy, vq[i].at);
        end

        // async reset away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 1);
        adv(2);
        en_req = 1'b0;
        rst_n  = 1'b1;
        adv(5);
        chk_all("after_rst", 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
